// File: rtl/ase_umsg_sched.sv
// UMsg scheduler: per-slot hint/data delay FSMs feeding a round-robin arbiter and a
// one-entry Rx output register. Define ASE_UMSG_HINT_EN to enable the hint phase.
module ase_umsg_sched #(
    parameter int unsigned NUM_UMSG    = 8,
    parameter int unsigned TIMER_WIDTH = 7,
    parameter int unsigned HINT_DELAY  = 16,
    parameter int unsigned DATA_DELAY  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        umsg_cmd_valid,
    input  logic [$clog2(NUM_UMSG)-1:0] umsg_cmd_id,
    input  logic                        umsg_cmd_hint,
    input  logic [511:0]                umsg_cmd_data,
    output logic                        rx_umsg_valid,
    input  logic                        rx_umsg_ready,
    output logic [27:0]                 rx_umsg_hdr,
    output logic [511:0]                rx_umsg_data,
    output logic [NUM_UMSG-1:0]         umsg_busy
);
    localparam int unsigned IdW = $clog2(NUM_UMSG);
    // Timers count down to zero, so a wait of N cycles loads N-1.
    localparam logic [TIMER_WIDTH-1:0] HintLoad = TIMER_WIDTH'(HINT_DELAY - 1);
    localparam logic [TIMER_WIDTH-1:0] DataLoad = TIMER_WIDTH'(DATA_DELAY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StHintWait,
        StSendHint,
        StDataWait,
        StSendData
    } slot_state_e;

    logic cmd_hint;
`ifdef ASE_UMSG_HINT_EN
    assign cmd_hint = umsg_cmd_hint;
`else
    logic unused_hint;
    assign unused_hint = umsg_cmd_hint;
    assign cmd_hint    = 1'b0;
`endif

    slot_state_e            state_q [NUM_UMSG];
    slot_state_e            state_d [NUM_UMSG];
    logic [TIMER_WIDTH-1:0] timer_q [NUM_UMSG];
    logic [TIMER_WIDTH-1:0] timer_d [NUM_UMSG];
    logic [511:0]           data_q  [NUM_UMSG];
    logic [511:0]           data_d  [NUM_UMSG];
    logic [IdW-1:0]         rr_q, rr_d;

    logic                   out_valid_q, out_valid_d;
    logic [27:0]            out_hdr_q, out_hdr_d;
    logic [511:0]           out_data_q, out_data_d;

    logic [NUM_UMSG-1:0]    cand, cmd_hit, granted;
    logic                   found, load, grant;
    logic [IdW-1:0]         winner;
    int unsigned            idx;

    always_comb begin
        for (int i = 0; i < NUM_UMSG; i++) begin
            cand[i]      = (state_q[i] == StSendHint) || (state_q[i] == StSendData);
            umsg_busy[i] = (state_q[i] != StIdle);
            cmd_hit[i]   = umsg_cmd_valid && (umsg_cmd_id == IdW'(i));
        end
    end

    // First candidate at or after rr_q, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_UMSG; k++) begin
            idx = (32'(rr_q) + k) % NUM_UMSG;
            if (!found && cand[idx[IdW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IdW-1:0];
            end
        end
    end

    assign load  = !out_valid_q || rx_umsg_ready;
    assign grant = load && found;

    always_comb begin
        for (int i = 0; i < NUM_UMSG; i++) begin
            granted[i] = grant && (winner == IdW'(i));
        end
    end

    always_comb begin
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_hdr_d   = out_hdr_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = found;
            if (found) begin
                rr_d                = (winner == IdW'(NUM_UMSG - 1)) ? '0 : winner + 1'b1;
                out_hdr_d           = '0;
                out_hdr_d[19:16]    = 4'h6;
                out_hdr_d[15]       = (state_q[winner] == StSendHint);
                out_hdr_d[5:0]      = 6'(winner);
                out_data_d          = (state_q[winner] == StSendHint) ? '0 : data_q[winner];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_UMSG; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            data_d[i]  = cmd_hit[i] ? umsg_cmd_data : data_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (cmd_hit[i]) begin
                        state_d[i] = cmd_hint ? StHintWait : StDataWait;
                        timer_d[i] = cmd_hint ? HintLoad : DataLoad;
                    end
                end
                StHintWait: begin
                    if (timer_q[i] == '0) state_d[i] = StSendHint;
                    else                  timer_d[i] = timer_q[i] - 1'b1;
                end
                StSendHint: begin
                    if (granted[i]) begin
                        state_d[i] = StDataWait;
                        timer_d[i] = DataLoad;
                    end
                end
                StDataWait: begin
                    if (timer_q[i] == '0) state_d[i] = StSendData;
                    else                  timer_d[i] = timer_q[i] - 1'b1;
                end
                StSendData: begin
                    // A command landing on the grant cycle restarts the slot instead of idling.
                    if (granted[i]) begin
                        if (cmd_hit[i]) begin
                            state_d[i] = cmd_hint ? StHintWait : StDataWait;
                            timer_d[i] = cmd_hint ? HintLoad : DataLoad;
                        end else begin
                            state_d[i] = StIdle;
                        end
                    end
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                state_q[i] <= StIdle;
                timer_q[i] <= '0;
                data_q[i]  <= '0;
            end
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_hdr_q   <= '0;
            out_data_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                data_q[i]  <= data_d[i];
            end
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_hdr_q   <= out_hdr_d;
            out_data_q  <= out_data_d;
        end
    end

    assign rx_umsg_valid = out_valid_q;
    assign rx_umsg_hdr   = out_hdr_q;
    assign rx_umsg_data  = out_data_q;

endmodule
